// File: rtl/phrase_sequencer_pkg.sv
// Types and constants shared by the phrase sequencer files.
// PHRASE_SEQ_LOOP_EN: defined = loop rows forever; undefined = stop in DONE after row 15.
package phrase_pkg;

    typedef struct packed {
        logic [7:0] note;
        logic [5:0] vol;
        logic [1:0] inst;
    } phrase_entry_t;

    localparam logic [15:0] EMPTY_ENTRY = 16'hFFFF;
    localparam logic [7:0]  NOTE_MAX    = 8'd107;
    localparam logic [7:0]  RST_NOTE    = 8'd36;
    localparam logic [5:0]  RST_VOL     = 6'd50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_HOLD
`ifndef PHRASE_SEQ_LOOP_EN
        , ST_DONE
`endif
    } state_t;

    function automatic logic [7:0] clamp_note(input logic [7:0] raw);
        return (raw > NOTE_MAX) ? NOTE_MAX : raw;
    endfunction

endpackage

// File: rtl/phrase_sequencer_if.sv
// Phrase-store row bus and per-channel voice outputs of the sequencer.
interface phrase_sequencer_if;

    logic [3:0]      row_o;
    logic [15:0]     channel_0;
    logic [15:0]     channel_1;
    logic [15:0]     channel_2;
    logic [15:0]     channel_3;
    logic [3:0][7:0] note_o;
    logic [3:0][5:0] vol_o;
    logic [3:0][1:0] inst_o;
    logic [3:0]      gate_o;
    logic [3:0]      key_on;

    modport master (
        output row_o, note_o, vol_o, inst_o, gate_o, key_on,
        input  channel_0, channel_1, channel_2, channel_3
    );

    modport slave (
        input  row_o, note_o, vol_o, inst_o, gate_o, key_on,
        output channel_0, channel_1, channel_2, channel_3
    );

endinterface

// File: rtl/phrase_sequencer_entry_decode.sv
// Splits a 16-bit phrase entry into note/vol/inst, clamping the note to the playable range.
module phrase_entry_decode
    import phrase_pkg::*;
(
    input  logic [15:0]   i_entry,
    output phrase_entry_t o_fields,
    output logic          o_empty
);

    assign o_empty       = (i_entry == EMPTY_ENTRY);
    assign o_fields.note = clamp_note(i_entry[15:8]);
    assign o_fields.vol  = i_entry[7:2];
    assign o_fields.inst = i_entry[1:0];

endmodule

// File: rtl/phrase_sequencer.sv
// Four-channel, 16-row phrase player: fetch a row, latch its entries, hold for row_period clocks.
// PHRASE_SEQ_LOOP_EN: defined = wrap to row 0 after row 15; undefined = stop in DONE until paused.
module phrase_sequencer
    import phrase_pkg::*;
#(
    parameter int CNT_W = 24
)
(
    input  logic             clk,
    input  logic             rst_active_high,
    input  logic             play_pause,
    input  logic [CNT_W-1:0] row_period,
    phrase_sequencer_if.master bus,
    output logic             phrase_end
);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [3:0][7:0] r_note;
    logic [3:0][5:0] r_vol;
    logic [3:0][1:0] r_inst;
    logic [3:0]      r_gate;
    logic [3:0]      r_key_on;

    logic [3:0][15:0]    w_entry;
    phrase_entry_t [3:0] w_fields;
    logic [3:0]          w_empty;
    logic                w_expire;
    logic                w_latch;
    logic                w_advance;
    logic                w_phrase_end;

    assign w_entry[0] = bus.channel_0;
    assign w_entry[1] = bus.channel_1;
    assign w_entry[2] = bus.channel_2;
    assign w_entry[3] = bus.channel_3;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dec
            phrase_entry_decode u_dec (
                .i_entry  (w_entry[g]),
                .o_fields (w_fields[g]),
                .o_empty  (w_empty[g])
            );
        end
    endgenerate

    assign w_expire = (r_cnt == r_period - CNT_W'(1));

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pause overrides every state, including a HOLD expiry in the same clock.
    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_advance    = 1'b0;
        w_phrase_end = 1'b0;
        if (!play_pause) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_FETCH;
                ST_FETCH: w_next = ST_LATCH;
                ST_LATCH: begin
                    w_next  = ST_HOLD;
                    w_latch = 1'b1;
                end
                ST_HOLD: begin
                    if (w_expire) begin
                        w_next    = ST_FETCH;
                        w_advance = 1'b1;
                        if (r_row == 4'd15) begin
                            w_phrase_end = 1'b1;
`ifndef PHRASE_SEQ_LOOP_EN
                            w_next = ST_DONE;
`endif
                        end
                    end
                end
`ifndef PHRASE_SEQ_LOOP_EN
                ST_DONE:  w_next = ST_DONE;
`endif
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_row    <= '0;
            r_cnt    <= '0;
            r_period <= CNT_W'(1);
            r_gate   <= '0;
            r_key_on <= '0;
            for (int i = 0; i < 4; i++) begin
                r_note[i] <= RST_NOTE;
                r_vol[i]  <= RST_VOL;
                r_inst[i] <= 2'd0;
            end
        end else begin
            r_key_on <= '0;
            if (!play_pause) begin
                r_gate <= '0;
                r_cnt  <= '0;
            end else if (w_latch) begin
                r_cnt    <= '0;
                r_period <= (row_period == '0) ? CNT_W'(1) : row_period;
                for (int i = 0; i < 4; i++) begin
                    if (!w_empty[i]) begin
                        r_note[i]   <= w_fields[i].note;
                        r_vol[i]    <= w_fields[i].vol;
                        r_inst[i]   <= w_fields[i].inst;
                        r_gate[i]   <= 1'b1;
                        r_key_on[i] <= 1'b1;
                    end
                end
            end else if (w_advance) begin
                // Row 15 + 1 wraps to 0 in both builds.
                r_cnt <= '0;
                r_row <= r_row + 4'd1;
`ifndef PHRASE_SEQ_LOOP_EN
                if (w_phrase_end) begin
                    r_gate <= '0;
                end
`endif
            end else if (r_state == ST_HOLD) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.row_o   = r_row;
    assign bus.note_o  = r_note;
    assign bus.vol_o   = r_vol;
    assign bus.inst_o  = r_inst;
    assign bus.gate_o  = r_gate;
    assign bus.key_on  = r_key_on;
    assign phrase_end  = w_phrase_end;

endmodule
